// File: rtl/periph_bus_pkg.sv
// periph_bus_pkg: shared types and defaults for the peripheral bus hub.
// Holds the FSM state encoding, the error data word and address-field defaults.
package periph_bus_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_WAIT_BUSY,
        S_WAIT_ACK,
        S_RESP
    } state_t;

    localparam logic [31:0] ERR_WORD_DEF = 32'hDEADBEEF;
    localparam int          N_CH_DEF     = 8;
    localparam int          CH_LSB_DEF   = 4;
    localparam int          SEL_W_DEF    = 4;
    localparam int          CNT_W        = 16;

endpackage

// File: rtl/periph_bus_decode.sv
// periph_bus_decode: combinational channel decode and per-channel muxing.
// Ports: addr_i (address above the offset field), ch_busy_i/ch_ack_i/ch_rdata_i
// (all channels); idx_o, unmapped_o, oh_o (one-hot select), busy_o/ack_o/rdata_o.
module periph_bus_decode #(
    parameter int                        N_CH   = 8,
    parameter int                        DATA_W = 32,
    parameter int                        ADDR_W = 32,
    parameter int                        CH_LSB = 4,
    parameter int                        SEL_W  = 4,
    parameter logic [ADDR_W-1:0]         BASE   = '0
) (
    input  logic [ADDR_W-CH_LSB-1:0]     addr_i,
    input  logic [N_CH-1:0]              ch_busy_i,
    input  logic [N_CH-1:0]              ch_ack_i,
    input  logic [N_CH*DATA_W-1:0]       ch_rdata_i,
    output logic [SEL_W-1:0]             idx_o,
    output logic                         unmapped_o,
    output logic [N_CH-1:0]              oh_o,
    output logic                         busy_o,
    output logic                         ack_o,
    output logic [DATA_W-1:0]            rdata_o
);

    localparam int UW = ADDR_W - CH_LSB - SEL_W;
    localparam logic [SEL_W:0] NCH_L = (SEL_W + 1)'(N_CH);

    logic [UW-1:0] upper;

    assign idx_o = addr_i[SEL_W-1:0];
    assign upper = addr_i[ADDR_W-CH_LSB-1:SEL_W];

    assign unmapped_o = (upper != BASE[UW-1:0]) ||
                        ({1'b0, idx_o} >= NCH_L);

    // Index values past N_CH select nothing, so the muxes read as 0.
    always_comb begin
        oh_o    = '0;
        busy_o  = 1'b0;
        ack_o   = 1'b0;
        rdata_o = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (idx_o == SEL_W'(i)) begin
                oh_o[i] = 1'b1;
                busy_o  = ch_busy_i[i];
                ack_o   = ch_ack_i[i];
                rdata_o = ch_rdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/periph_bus_hub.sv
// periph_bus_hub: single-beat request to N_CH peripheral channel fabric.
// Ports: req_* request side, resp_* response pulse, ch_* channel side,
// err_count / last_err_addr error statistics. All outputs registered
// except req_ready, which is a decode of the IDLE state.
module periph_bus_hub
    import periph_bus_pkg::*;
#(
    parameter int                N_CH     = N_CH_DEF,
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                CH_LSB   = CH_LSB_DEF,
    parameter int                SEL_W    = SEL_W_DEF,
    parameter logic [ADDR_W-1:0] BASE     = '0,
    parameter int                TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ERR_WORD = DATA_W'(ERR_WORD_DEF)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_wr,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [DATA_W-1:0]        req_wdata,
    output logic                     resp_valid,
    output logic [DATA_W-1:0]        resp_rdata,
    output logic                     resp_err,
    output logic [N_CH-1:0]          ch_stb,
    output logic                     ch_wr,
    output logic [CH_LSB-1:0]        ch_addr,
    output logic [DATA_W-1:0]        ch_wdata,
    input  logic [N_CH-1:0]          ch_busy,
    input  logic [N_CH-1:0]          ch_ack,
    input  logic [N_CH*DATA_W-1:0]   ch_rdata,
    output logic [7:0]               err_count,
    output logic [ADDR_W-1:0]        last_err_addr
);

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                wr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   data_q;
    logic                err_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W:0]      cnt_d;
    logic [N_CH-1:0]     stb_q;
    logic                resp_valid_q;
    logic [DATA_W-1:0]   resp_rdata_q;
    logic                resp_err_q;
    logic [7:0]          err_count_q;
    logic [ADDR_W-1:0]   last_err_q;

    logic [SEL_W-1:0]    idx;
    logic                unmapped;
    logic [N_CH-1:0]     oh;
    logic                busy_sel;
    logic                ack_sel;
    logic [DATA_W-1:0]   rdata_sel;
    logic                tmo;
    logic                stb_live;

    periph_bus_decode #(
        .N_CH   (N_CH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .CH_LSB (CH_LSB),
        .SEL_W  (SEL_W),
        .BASE   (BASE)
    ) u_dec (
        .addr_i     (addr_q[ADDR_W-1:CH_LSB]),
        .ch_busy_i  (ch_busy),
        .ch_ack_i   (ch_ack),
        .ch_rdata_i (ch_rdata),
        .idx_o      (idx),
        .unmapped_o (unmapped),
        .oh_o       (oh),
        .busy_o     (busy_sel),
        .ack_o      (ack_sel),
        .rdata_o    (rdata_sel)
    );

    assign cnt_d    = {1'b0, cnt_q} + (CNT_W + 1)'(1);
    assign tmo      = (cnt_d >= (CNT_W + 1)'(TIMEOUT));
    // An ack seen while our strobe is still high is too early to count.
    assign stb_live = |stb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            wr_q         <= 1'b0;
            wdata_q      <= '0;
            data_q       <= '0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
            stb_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            err_count_q  <= '0;
            last_err_q   <= '0;
        end else begin
            stb_q        <= '0;
            resp_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        wr_q    <= req_wr;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    cnt_q  <= '0;
                    data_q <= '0;
                    err_q  <= unmapped;
                    if (unmapped) begin
                        state_q <= S_RESP;
                    end else if (busy_sel) begin
                        state_q <= S_WAIT_BUSY;
                    end else begin
                        stb_q   <= oh;
                        state_q <= S_WAIT_ACK;
                    end
                end
                S_WAIT_BUSY: begin
                    cnt_q <= cnt_d[CNT_W-1:0];
                    if (tmo) begin
                        err_q   <= 1'b1;
                        state_q <= S_RESP;
                    end else if (!busy_sel) begin
                        stb_q   <= oh;
                        state_q <= S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    cnt_q <= cnt_d[CNT_W-1:0];
                    // Ack is tested first so it wins over a same-cycle timeout.
                    if (ack_sel && !stb_live) begin
                        data_q  <= wr_q ? '0 : rdata_sel;
                        state_q <= S_RESP;
                    end else if (tmo) begin
                        err_q   <= 1'b1;
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= err_q;
                    resp_rdata_q <= err_q ? ERR_WORD : data_q;
                    if (err_q) begin
                        last_err_q <= addr_q;
                        if (err_count_q != 8'hFF) begin
                            err_count_q <= err_count_q + 8'd1;
                        end
                    end
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready     = (state_q == S_IDLE);
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;
    assign resp_err      = resp_err_q;
    assign ch_stb        = stb_q;
    assign ch_wr         = wr_q;
    assign ch_addr       = addr_q[CH_LSB-1:0];
    assign ch_wdata      = wdata_q;
    assign err_count     = err_count_q;
    assign last_err_addr = last_err_q;

endmodule

// File: tb/tb_periph_bus_hub.sv
// tb_periph_bus_hub: directed and randomized checks of periph_bus_hub.
// Expected timing and data come from a transaction-level model of the hub.
module tb_periph_bus_hub;

    localparam int          TMO = 16;
    localparam logic [31:0] EW  = 32'hDEADBEEF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_wr = 1'b0;
    logic [31:0]   req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [7:0]    ch_stb;
    logic          ch_wr;
    logic [3:0]    ch_addr;
    logic [31:0]   ch_wdata;
    logic [7:0]    ch_busy = '0;
    logic [7:0]    ch_ack = '0;
    logic [255:0]  ch_rdata = '0;
    logic [7:0]    err_count;
    logic [31:0]   last_err_addr;

    int errors = 0;
    int checks = 0;
    int errc_m = 0;
    logic [31:0] last_m = '0;

    always #5 clk = ~clk;

    periph_bus_hub #(.TIMEOUT(TMO)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_wr        (req_wr),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .ch_stb        (ch_stb),
        .ch_wr         (ch_wr),
        .ch_addr       (ch_addr),
        .ch_wdata      (ch_wdata),
        .ch_busy       (ch_busy),
        .ch_ack        (ch_ack),
        .ch_rdata      (ch_rdata),
        .err_count     (err_count),
        .last_err_addr (last_err_addr)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One request; b = cycles own busy stays high from the handshake,
    // k = ack delay after strobe, early = extra own ack in the strobe cycle.
    task automatic txn(input logic [31:0] addr, input logic wr,
                       input logic [31:0] wd, input int b, input int k,
                       input bit early, input bit noise,
                       input logic [31:0] rd);
        int          idx;
        bit          mapped;
        int          exp_s;
        int          exp_r;
        bit          exp_err;
        logic [31:0] exp_d;
        int          got_s;
        int          got_r;
        int          nstb;
        int          nresp;
        logic [7:0]  s_oh;
        logic        s_wr;
        logic [3:0]  s_addr;
        logic [31:0] s_wd;
        logic [31:0] r_d;
        logic        r_e;
        logic [7:0]  bz;
        logic [7:0]  az;

        idx    = int'(addr[7:4]);
        mapped = (addr[31:8] == 24'h0) && (idx < 8);
        exp_s  = -1;
        if (!mapped) begin
            exp_r   = 2;
            exp_err = 1'b1;
        end else if (b >= TMO) begin
            exp_r   = TMO + 2;
            exp_err = 1'b1;
        end else begin
            exp_s = b + 1;
            if (exp_s + k <= TMO) begin
                exp_r   = exp_s + k + 2;
                exp_err = 1'b0;
            end else begin
                exp_r   = TMO + 2;
                exp_err = 1'b1;
            end
        end
        exp_d = exp_err ? EW : (wr ? 32'h0 : rd);

        for (int i = 0; i < 8; i++) begin
            ch_rdata[i*32 +: 32] = noise ? $urandom : 32'h0;
        end
        if (mapped) ch_rdata[idx*32 +: 32] = rd;
        bz = noise ? 8'($urandom) : 8'h0;
        if (mapped) bz[idx] = (b > 0);
        ch_busy = bz;
        ch_ack  = '0;

        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wd;
        chk("ready_idle", {63'h0, req_ready}, 64'h1);
        step();
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_wr    = ~wr;
        chk("ready_drop", {63'h0, req_ready}, 64'h0);

        got_s = -1;
        got_r = -1;
        nstb  = 0;
        nresp = 0;
        s_oh  = '0;
        s_wr  = 1'b0;
        s_addr = '0;
        s_wd  = '0;
        r_d   = '0;
        r_e   = 1'b0;
        for (int n = 0; n < TMO + 10; n++) begin
            if (ch_stb != 8'h0) begin
                nstb++;
                got_s  = n;
                s_oh   = ch_stb;
                s_wr   = ch_wr;
                s_addr = ch_addr;
                s_wd   = ch_wdata;
            end
            if (resp_valid) begin
                nresp++;
                got_r = n;
                r_d   = resp_rdata;
                r_e   = resp_err;
            end
            bz = noise ? 8'($urandom) : 8'h0;
            az = noise ? 8'($urandom) : 8'h0;
            if (mapped) begin
                bz[idx] = (n < b);
                az[idx] = (got_s >= 0) &&
                          ((n == got_s + k) || (early && n == got_s));
            end
            ch_busy = bz;
            ch_ack  = az;
            step();
        end
        ch_busy = '0;
        ch_ack  = '0;

        if (exp_err) begin
            errc_m = (errc_m == 255) ? 255 : errc_m + 1;
            last_m = addr;
        end

        chk("stb_count", 64'(nstb), (exp_s >= 0) ? 64'h1 : 64'h0);
        if (exp_s >= 0) begin
            chk("stb_time", 64'(got_s), 64'(exp_s));
            chk("stb_onehot", {56'h0, s_oh}, 64'(8'h1 << idx));
            chk("stb_wr", {63'h0, s_wr}, {63'h0, wr});
            chk("stb_addr", {60'h0, s_addr}, {60'h0, addr[3:0]});
            chk("stb_wdata", {32'h0, s_wd}, {32'h0, wd});
        end
        chk("resp_count", 64'(nresp), 64'h1);
        chk("resp_time", 64'(got_r), 64'(exp_r));
        chk("resp_rdata", {32'h0, r_d}, {32'h0, exp_d});
        chk("resp_err", {63'h0, r_e}, {63'h0, exp_err});
        chk("err_count", {56'h0, err_count}, 64'(errc_m));
        chk("last_err", {32'h0, last_err_addr}, {32'h0, last_m});
    endtask

    initial begin
        int          got;
        int          sel;
        logic [31:0] a;
        int          b;
        int          k;

        #1;
        chk("rst_ready", {63'h0, req_ready}, 64'h1);
        chk("rst_resp", {63'h0, resp_valid}, 64'h0);
        chk("rst_stb", {56'h0, ch_stb}, 64'h0);
        chk("rst_errc", {56'h0, err_count}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Read ch3, ack 2 cycles after the strobe.
        txn(32'h34, 1'b0, 32'h0, 0, 2, 1'b0, 1'b0, 32'h12345678);
        // Write ch0.
        txn(32'h00, 1'b1, 32'hA5A5A5A5, 0, 1, 1'b0, 1'b0, 32'h55AA55AA);
        // Unmapped index 9.
        txn(32'h94, 1'b0, 32'h0, 0, 1, 1'b0, 1'b0, 32'h0);
        // Unmapped upper field.
        txn(32'h0000_0120, 1'b1, 32'h1, 0, 1, 1'b0, 1'b0, 32'h0);
        // Busy for 10 cycles on ch5.
        txn(32'h5C, 1'b0, 32'h0, 10, 3, 1'b0, 1'b0, 32'hCAFEF00D);
        // Never acks: timeout.
        txn(32'h24, 1'b0, 32'h0, 0, 100, 1'b0, 1'b0, 32'h11111111);
        // Ack on the last allowed cycle wins over the timeout.
        txn(32'h24, 1'b0, 32'h0, 0, TMO - 1, 1'b0, 1'b0, 32'h22222222);
        // One cycle too late: timeout.
        txn(32'h24, 1'b0, 32'h0, 0, TMO, 1'b0, 1'b0, 32'h33333333);
        // Busy never clears in time.
        txn(32'h74, 1'b1, 32'h7, TMO, 1, 1'b0, 1'b0, 32'h0);
        // Early ack in strobe cycle plus other-channel noise.
        txn(32'h68, 1'b0, 32'h0, 0, 3, 1'b1, 1'b1, 32'h0BADCAFE);

        // Reset while waiting for the ack.
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_addr  = 32'h24;
        step();
        req_valid = 1'b0;
        got = 0;
        for (int n = 0; n < 8 && got == 0; n++) begin
            if (ch_stb != 8'h0) got = 1;
            else step();
        end
        chk("rst_mid_stb_seen", 64'(got), 64'h1);
        step();
        rst = 1'b1;
        #1;
        chk("rst_mid_ready", {63'h0, req_ready}, 64'h1);
        chk("rst_mid_stb", {56'h0, ch_stb}, 64'h0);
        chk("rst_mid_errc", {56'h0, err_count}, 64'h0);
        chk("rst_mid_last", {32'h0, last_err_addr}, 64'h0);
        chk("rst_mid_wdata", {32'h0, ch_wdata}, 64'h0);
        errc_m = 0;
        last_m = '0;
        ch_ack = 8'h04;
        for (int n = 0; n < 3; n++) begin
            step();
            chk("rst_mid_noresp", {63'h0, resp_valid}, 64'h0);
        end
        ch_ack = '0;
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("rst_mid_noresp2", {63'h0, resp_valid}, 64'h0);
        txn(32'h38, 1'b0, 32'h0, 0, 1, 1'b0, 1'b0, 32'h87654321);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            sel = $urandom_range(0, 9);
            if (sel < 8) begin
                a = {24'h0, 4'(sel), 4'($urandom)};
            end else if (sel == 8) begin
                a = {24'h0, 4'($urandom_range(8, 15)), 4'($urandom)};
            end else begin
                a = $urandom | 32'h100;
            end
            b = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 18) : 0;
            k = ($urandom_range(0, 5) == 0) ? $urandom_range(10, 20)
                                            : $urandom_range(1, 4);
            txn(a, 1'($urandom), $urandom, b, k, 1'($urandom),
                1'b1, $urandom);
        end

        // Drive err_count into saturation.
        for (int t = 0; t < 260; t++) begin
            txn({24'h0, 4'($urandom_range(8, 15)), 4'($urandom)},
                1'b0, 32'h0, 0, 1, 1'b0, 1'b0, 32'h0);
        end
        chk("err_sat", {56'h0, err_count}, 64'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
